count_capture: RTL and testbench

Timestamp capture stage downstream of the 8-bit free-running counter.
- Consumes the counter's `count` and `overflow` outputs.
- Extends `count` with an epoch register that advances on each overflow.
- Latches the extended timestamp `{epoch, count}` on rising edges of an event input.
- Buffers captures in a small FIFO and drains them through a valid/ready handshake to the host/bus-side reader.

---
 rtl/count_capture_pkg.sv | 12 +
 rtl/ts_fifo.sv | 52 +++++
 rtl/count_capture.sv | 114 +++++++++++
 tb/tb_count_capture.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/count_capture_pkg.sv
// Shared types and constants for the count_capture timestamp stage.
package count_capture_pkg;

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] DROP_CNT_MAX = 8'hFF;

    typedef enum logic {
        CAP_DISARMED = 1'b0,
        CAP_ARMED    = 1'b1
    } cap_state_t;

endpackage

// File: rtl/ts_fifo.sv
// Fall-through FIFO for captured timestamps: dout shows the head entry, zero while empty.
module ts_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   used;
    logic          do_push;
    logic          do_pop;

    assign full    = (used == (AW+1)'(DEPTH));
    assign empty   = (used == '0);
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO still succeeds when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            used   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   used <= used + (AW+1)'(1);
                2'b01:   used <= used - (AW+1)'(1);
                default: used <= used;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/count_capture.sv
// Timestamp capture: epoch-extended counter latched on event edges and queued for the reader.
// Optional drop counter is built when COUNT_CAPTURE_DROP_CNT_EN is defined.
module count_capture
    import count_capture_pkg::*;
#(
    parameter int EPOCH_W  = 8,
    parameter int DEPTH    = 4,
    parameter int ONE_SHOT = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CNT_W-1:0]         count,
    input  logic                     overflow,
    input  logic                     event_in,
    input  logic                     arm,
    input  logic                     disarm,
    output logic                     armed,
    output logic [EPOCH_W+CNT_W-1:0] ts_data,
    output logic                     ts_valid,
    input  logic                     ts_ready,
    output logic                     lost,
    input  logic                     lost_clr,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int TS_W = EPOCH_W + CNT_W;

    logic [EPOCH_W-1:0] epoch;
    logic               event_q;
    logic               event_edge;
    cap_state_t         state;
    cap_state_t         state_next;
    logic               push_req;
    logic               push_ok;
    logic               pop;
    logic               drop;
    logic               fifo_full;
    logic               fifo_empty;

    assign event_edge = event_in & ~event_q;
    assign armed      = (state == CAP_ARMED);
    assign ts_valid   = ~fifo_empty;
    assign pop        = ts_valid & ts_ready;
    assign push_req   = event_edge & armed;
    assign push_ok    = push_req & (~fifo_full | pop);
    assign drop       = push_req & fifo_full & ~pop;

    // event_q resets high so a level held through reset is not seen as an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            epoch   <= '0;
            event_q <= 1'b1;
            state   <= CAP_DISARMED;
        end else begin
            event_q <= event_in;
            state   <= state_next;
            if (overflow) epoch <= epoch + EPOCH_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        if (disarm) begin
            state_next = CAP_DISARMED;
        end else if (state == CAP_DISARMED) begin
            if (arm) state_next = CAP_ARMED;
        end else if ((ONE_SHOT != 0) && push_ok) begin
            state_next = CAP_DISARMED;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lost <= 1'b0;
        end else if (drop) begin
            lost <= 1'b1;
        end else if (lost_clr) begin
            lost <= 1'b0;
        end
    end

`ifdef COUNT_CAPTURE_DROP_CNT_EN
    logic [CNT_W-1:0] drop_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_q <= '0;
        end else if (lost_clr) begin
            drop_q <= drop ? CNT_W'(1) : '0;
        end else if (drop && (drop_q != DROP_CNT_MAX)) begin
            drop_q <= drop_q + CNT_W'(1);
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = '0;
`endif

    ts_fifo #(
        .W     (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_ok),
        .pop   (pop),
        .din   ({epoch, count}),
        .dout  (ts_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_count_capture.sv
// Bench for count_capture: a continuous-mode and a one-shot instance share directed stimulus
// and are checked every cycle against a queue-based model plus literal expectations.
module tb_count_capture;

    localparam int DEPTH = 4;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n    = 1'b0;
    logic [7:0] count    = 8'h00;
    logic       overflow = 1'b0;
    logic       event_in = 1'b0;
    logic       arm      = 1'b0;
    logic       disarm   = 1'b0;
    logic       ts_ready = 1'b0;
    logic       lost_clr = 1'b0;

    logic        armed0, ts_valid0, lost0;
    logic [15:0] ts_data0;
    logic [7:0]  drop_cnt0;
    logic        armed1, ts_valid1, lost1;
    logic [15:0] ts_data1;
    logic [7:0]  drop_cnt1;

    count_capture #(.EPOCH_W(8), .DEPTH(DEPTH), .ONE_SHOT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .count(count), .overflow(overflow), .event_in(event_in),
        .arm(arm), .disarm(disarm), .armed(armed0), .ts_data(ts_data0), .ts_valid(ts_valid0),
        .ts_ready(ts_ready), .lost(lost0), .lost_clr(lost_clr), .drop_cnt(drop_cnt0)
    );

    count_capture #(.EPOCH_W(8), .DEPTH(DEPTH), .ONE_SHOT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .count(count), .overflow(overflow), .event_in(event_in),
        .arm(arm), .disarm(disarm), .armed(armed1), .ts_data(ts_data1), .ts_valid(ts_valid1),
        .ts_ready(ts_ready), .lost(lost1), .lost_clr(lost_clr), .drop_cnt(drop_cnt1)
    );

    // scoreboard
    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];
    bit          m_armed[2];
    bit          m_lost[2];
    int          m_drop[2];
    logic [7:0]  m_epoch;
    bit          m_evprev;
    bit          model_live = 1'b0;
    bit          m_edge, m_pop, m_req, m_acc, m_drp;

    function automatic int q_size(input int i);
        return (i == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic logic [15:0] q_front(input int i);
        return (i == 0) ? exp_q0[0] : exp_q1[0];
    endfunction

    task automatic q_pop(input int i);
        if (i == 0) void'(exp_q0.pop_front());
        else        void'(exp_q1.pop_front());
    endtask

    task automatic q_push(input int i, input logic [15:0] v);
        if (i == 0) exp_q0.push_back(v);
        else        exp_q1.push_back(v);
    endtask

    // model: one step per rising clock, using the inputs held across that edge
    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q0.delete();
            exp_q1.delete();
            for (int i = 0; i < 2; i++) begin
                m_armed[i] = 1'b0;
                m_lost[i]  = 1'b0;
                m_drop[i]  = 0;
            end
            m_epoch    = 8'h00;
            m_evprev   = 1'b1;
            model_live = 1'b1;
        end else begin
            m_edge = event_in && !m_evprev;
            for (int i = 0; i < 2; i++) begin
                m_pop = (q_size(i) > 0) && ts_ready;
                m_req = m_edge && m_armed[i];
                m_acc = m_req && ((q_size(i) < DEPTH) || m_pop);
                m_drp = m_req && !m_acc;
                if (m_pop) q_pop(i);
                if (m_acc) q_push(i, {m_epoch, count});
                if (disarm)                        m_armed[i] = 1'b0;
                else if (arm && !m_armed[i])       m_armed[i] = 1'b1;
                else if ((i == 1) && m_acc)        m_armed[i] = 1'b0;
                if (m_drp)         m_lost[i] = 1'b1;
                else if (lost_clr) m_lost[i] = 1'b0;
`ifdef COUNT_CAPTURE_DROP_CNT_EN
                if (lost_clr)                    m_drop[i] = m_drp ? 1 : 0;
                else if (m_drp && m_drop[i] < 255) m_drop[i] = m_drop[i] + 1;
`else
                m_drop[i] = 0;
`endif
            end
            m_evprev = event_in;
            if (overflow) m_epoch = m_epoch + 8'd1;
        end
    end

    // compare process, sampled on the falling edge
    always @(negedge clk) begin
        if (model_live) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("u%0d armed", i), {31'd0, (i == 0) ? armed0 : armed1}, {31'd0, m_armed[i]});
                check($sformatf("u%0d ts_valid", i), {31'd0, (i == 0) ? ts_valid0 : ts_valid1},
                      {31'd0, q_size(i) > 0});
                if (q_size(i) > 0)
                    check($sformatf("u%0d ts_data", i), {16'd0, (i == 0) ? ts_data0 : ts_data1},
                          {16'd0, q_front(i)});
                check($sformatf("u%0d lost", i), {31'd0, (i == 0) ? lost0 : lost1}, {31'd0, m_lost[i]});
                check($sformatf("u%0d drop_cnt", i), {24'd0, (i == 0) ? drop_cnt0 : drop_cnt1}, m_drop[i]);
            end
        end
    end

    // driver
    task automatic step();
        @(posedge clk);
        #1;
        arm      = 1'b0;
        disarm   = 1'b0;
        lost_clr = 1'b0;
    endtask

    logic [7:0] exp_drop1;

    initial begin
`ifdef COUNT_CAPTURE_DROP_CNT_EN
        exp_drop1 = 8'd1;
`else
        exp_drop1 = 8'd0;
`endif
        // reset state
        step(); step();
        check("reset ts_valid", {31'd0, ts_valid0}, 32'd0);
        check("reset ts_data", {16'd0, ts_data0}, 32'd0);
        check("reset armed", {31'd0, armed0}, 32'd0);
        rst_n = 1'b1;
        step();

        // 1: basic capture and pop
        count = 8'h10; arm = 1'b1; step();
        event_in = 1'b1; step();
        check("t1 valid", {31'd0, ts_valid0}, 32'd1);
        check("t1 data", {16'd0, ts_data0}, 32'h0010);
        event_in = 1'b0; ts_ready = 1'b1; step();
        check("t1 popped", {31'd0, ts_valid0}, 32'd0);
        ts_ready = 1'b0;

        // 2: overflow boundary
        arm = 1'b1; step();
        count = 8'hFF; overflow = 1'b1; event_in = 1'b1; step();
        count = 8'h00; overflow = 1'b0; event_in = 1'b0; step();
        event_in = 1'b1; step();
        event_in = 1'b0; step();
        check("t2 first", {16'd0, ts_data0}, 32'h00FF);
        ts_ready = 1'b1; step();
        check("t2 second", {16'd0, ts_data0}, 32'h0100);
        step();
        check("t2 drained", {31'd0, ts_valid0}, 32'd0);
        ts_ready = 1'b0;

        // 3: fill, drop, push with pop, clear
        for (int i = 0; i < 5; i++) begin
            count = 8'h20 + 8'(i); event_in = 1'b1; step();
            event_in = 1'b0; step();
        end
        check("t3 lost", {31'd0, lost0}, 32'd1);
        check("t3 drop_cnt", {24'd0, drop_cnt0}, {24'd0, exp_drop1});
        count = 8'h25; event_in = 1'b1; ts_ready = 1'b1; step();
        check("t3 head after pop", {16'd0, ts_data0}, 32'h0121);
        check("t3 lost kept", {31'd0, lost0}, 32'd1);
        event_in = 1'b0; ts_ready = 1'b0; step();
        lost_clr = 1'b1; step();
        check("t3 lost clr", {31'd0, lost0}, 32'd0);
        check("t3 drop clr", {24'd0, drop_cnt0}, 32'd0);
        ts_ready = 1'b1;
        repeat (4) step();
        check("t3 drained", {31'd0, ts_valid0}, 32'd0);
        ts_ready = 1'b0;

        // 4: one-shot instance
        arm = 1'b1; step();
        check("t4 armed", {31'd0, armed1}, 32'd1);
        event_in = 1'b1; step();
        check("t4 disarmed", {31'd0, armed1}, 32'd0);
        check("t4 one entry", {31'd0, ts_valid1}, 32'd1);
        event_in = 1'b0; step(); step();
        event_in = 1'b1; step();
        event_in = 1'b0; ts_ready = 1'b1; step();
        check("t4 single", {31'd0, ts_valid1}, 32'd0);
        step();
        ts_ready = 1'b0;
        arm = 1'b1; disarm = 1'b1; step();
        check("t4 arm+disarm", {31'd0, armed1}, 32'd0);

        // 5: event held high through reset
        event_in = 1'b1; count = 8'h33;
        rst_n = 1'b0; step(); step();
        rst_n = 1'b1; step();
        arm = 1'b1; step(); step(); step();
        check("t5 no capture", {31'd0, ts_valid0}, 32'd0);
        event_in = 1'b0; step();
        event_in = 1'b1; step();
        check("t5 capture", {16'd0, ts_data0}, 32'h0033);

        // 6: reset with entries queued
        event_in = 1'b0; step();
        count = 8'h34; event_in = 1'b1; step();
        event_in = 1'b0; step();
        count = 8'h35; event_in = 1'b1; step();
        event_in = 1'b0;
        check("t6 queued", {31'd0, ts_valid0}, 32'd1);
        rst_n = 1'b0; step();
        check("t6 rst valid", {31'd0, ts_valid0}, 32'd0);
        check("t6 rst armed", {31'd0, armed0}, 32'd0);
        rst_n = 1'b1; step(); step();
        check("t6 no residue", {31'd0, ts_valid0}, 32'd0);
        count = 8'h05; arm = 1'b1; step();
        event_in = 1'b1; step();
        check("t6 epoch zero", {16'd0, ts_data0}, 32'h0005);
        event_in = 1'b0; step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
